// File: rtl/hemlo.sv
// hemlo: edge detector for an asynchronous level input such as a GPS PPS
// signal. It synchronises the input into clk, emits one-cycle rising and
// falling strobes, counts rising edges and measures the clk-cycle spacing
// between consecutive rising edges.
module hemlo #(
    parameter int SYNC_STAGES = 2,   // synchroniser depth, 2..4
    parameter int CNT_W       = 16,  // width of edge_count
    parameter int PERIOD_W    = 32   // width of period counter and period
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig,
    output logic                pe,
    output logic                ne,
    output logic [CNT_W-1:0]    edge_count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                period_ovf
);

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [CNT_W-1:0]    COUNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;        // r_sync[0] samples sig first
    logic                   r_prev;        // last synchronised level
    logic                   r_pe;
    logic                   r_ne;
    logic [CNT_W-1:0]       r_edge_count;
    logic [PERIOD_W-1:0]    r_period_cnt;  // cycles since the last rising strobe
    logic [PERIOD_W-1:0]    r_period;
    logic                   r_period_valid;
    logic                   r_period_ovf;
    logic                   r_seen_first;  // a rising strobe has occurred since reset

    logic                   w_sync_last;
    logic                   w_rise;
    logic                   w_fall;

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    // A rising strobe is being registered on this clock edge.
    assign w_rise      = w_sync_last & ~r_prev;
    assign w_fall      = ~w_sync_last & r_prev;

    // Synchroniser chain and history flop for the edge comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            // NOTE: every flop update uses <= so all registers see the
            // pre-edge values; with = the chain would collapse into one stage.
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig};
            r_prev <= w_sync_last;
        end
    end

    // Registered one-cycle edge strobes; rise and fall are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pe <= 1'b0;
            r_ne <= 1'b0;
        end else begin
            r_pe <= w_rise;
            r_ne <= w_fall;
        end
    end

    // Rising-edge counter, wraps silently at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_count <= '0;
        end else if (w_rise) begin
            r_edge_count <= r_edge_count + COUNT_ONE;
        end
    end

    // Free-running saturating period counter, reloaded to 1 on each rising strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_rise) begin
            r_period_cnt <= PERIOD_ONE;
        end else if (r_period_cnt != PERIOD_MAX) begin
            r_period_cnt <= r_period_cnt + PERIOD_ONE;
        end
    end

    // Capture the period on every rising strobe except the first after reset,
    // which only starts the measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_period_ovf   <= 1'b0;
            r_seen_first   <= 1'b0;
        end else if (w_rise) begin
            r_seen_first <= 1'b1;
            if (r_seen_first) begin
                r_period       <= r_period_cnt;
                r_period_valid <= 1'b1;
                r_period_ovf   <= (r_period_cnt == PERIOD_MAX);
            end
        end
    end

    assign pe           = r_pe;
    assign ne           = r_ne;
    assign edge_count   = r_edge_count;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign period_ovf   = r_period_ovf;

endmodule

// File: tb/tb_hemlo.sv
// tb_hemlo: directed self-checking bench for hemlo. Three instances share
// clk and rst: default parameters, a 4-bit period counter for saturation,
// and a 2-bit edge counter for wrap-around and reset-with-input-high.
module tb_hemlo;

    logic clk = 1'b0;
    logic rst;
    logic sig_m, sig_o, sig_w;

    logic        pe_m, ne_m, pv_m, ovf_m;
    logic [15:0] ec_m;
    logic [31:0] period_m;

    logic        pe_o, ne_o, pv_o, ovf_o;
    logic [15:0] ec_o;
    logic [3:0]  period_o;

    logic        pe_w, ne_w, pv_w, ovf_w;
    logic [1:0]  ec_w;
    logic [31:0] period_w;

    int n_vec  = 0;
    int n_miss = 0;

    // Strobe tallies, sampled at posedge (pre-update value = previous cycle).
    int pe_cnt_m = 0;
    int ne_cnt_m = 0;
    int both_m   = 0;
    int pe_cnt_w = 0;

    hemlo u_main (
        .clk(clk), .rst(rst), .sig(sig_m), .pe(pe_m), .ne(ne_m),
        .edge_count(ec_m), .period(period_m), .period_valid(pv_m), .period_ovf(ovf_m)
    );

    hemlo #(.PERIOD_W(4)) u_ovf (
        .clk(clk), .rst(rst), .sig(sig_o), .pe(pe_o), .ne(ne_o),
        .edge_count(ec_o), .period(period_o), .period_valid(pv_o), .period_ovf(ovf_o)
    );

    hemlo #(.CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .sig(sig_w), .pe(pe_w), .ne(ne_w),
        .edge_count(ec_w), .period(period_w), .period_valid(pv_w), .period_ovf(ovf_w)
    );

    // 20 ns clock, rising edges at 10, 30, 50 ns ...
    always #10 clk = ~clk;

    // Count strobes observed on the main and wrap instances.
    always @(posedge clk) begin
        if (pe_m) pe_cnt_m <= pe_cnt_m + 1;
        if (ne_m) ne_cnt_m <= ne_cnt_m + 1;
        if (pe_m && ne_m) both_m <= both_m + 1;
        if (pe_w) pe_cnt_w <= pe_cnt_w + 1;
    end

    // One rising edge, then sample/drive at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int pe_snap;
        int ne_snap;

        // ---------------- reset ----------------
        rst   = 1'b1;
        sig_m = 1'b0;
        sig_o = 1'b0;
        sig_w = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_pe", 32'(pe_m), 32'd0);
        check("rst_ne", 32'(ne_m), 32'd0);
        check("rst_edge_count", 32'(ec_m), 32'd0);
        check("rst_period", period_m, 32'd0);
        check("rst_period_valid", 32'(pv_m), 32'd0);
        check("rst_period_ovf", 32'(ovf_m), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_pe", 32'(pe_m), 32'd0);
            check("idle_ne", 32'(ne_m), 32'd0);
        end

        // ---------------- single rising edge: latency 3 edges ----------------
        sig_m = 1'b1;
        step();
        check("lat_pe_k", 32'(pe_m), 32'd0);
        step();
        check("lat_pe_k1", 32'(pe_m), 32'd0);
        step();
        check("lat_pe_k2", 32'(pe_m), 32'd1);
        check("single_edge_count", 32'(ec_m), 32'd1);
        check("single_ne", 32'(ne_m), 32'd0);
        check("single_period_valid", 32'(pv_m), 32'd0);
        step();
        check("lat_pe_k3", 32'(pe_m), 32'd0);

        // ---------------- periodic input, rises 100 cycles apart ----------------
        repeat (46) step();
        sig_m = 1'b0;
        step();
        step();
        check("ne_lat_early", 32'(ne_m), 32'd0);
        step();
        check("ne_lat", 32'(ne_m), 32'd1);
        check("ne_lat_pe", 32'(pe_m), 32'd0);
        repeat (47) step();
        check("pre2_period_valid", 32'(pv_m), 32'd0);
        sig_m = 1'b1;
        for (int r = 2; r <= 4; r++) begin
            repeat (3) step();
            check("per_pe", 32'(pe_m), 32'd1);
            check("per_edge_count", 32'(ec_m), 32'(r));
            check("per_period_valid", 32'(pv_m), 32'd1);
            check("per_period", period_m, 32'd100);
            check("per_period_ovf", 32'(ovf_m), 32'd0);
            repeat (47) step();
            sig_m = 1'b0;
            repeat (50) step();
            if (r < 4) sig_m = 1'b1;
        end
        check("per_pe_total", 32'(pe_cnt_m), 32'd4);
        check("per_ne_total", 32'(ne_cnt_m), 32'd4);

        // ---------------- short pulse: one sampled high edge ----------------
        pe_snap = pe_cnt_m;
        ne_snap = ne_cnt_m;
        sig_m = 1'b1;
        step();
        sig_m = 1'b0;
        step();
        check("short_pe_k1", 32'(pe_m), 32'd0);
        step();
        check("short_pe", 32'(pe_m), 32'd1);
        check("short_ne_early", 32'(ne_m), 32'd0);
        step();
        check("short_pe_off", 32'(pe_m), 32'd0);
        check("short_ne", 32'(ne_m), 32'd1);
        step();
        check("short_ne_off", 32'(ne_m), 32'd0);
        repeat (5) step();
        check("short_pe_count", 32'(pe_cnt_m - pe_snap), 32'd1);
        check("short_ne_count", 32'(ne_cnt_m - ne_snap), 32'd1);
        check("short_edge_count", 32'(ec_m), 32'd5);
        check("no_pe_ne_overlap", 32'(both_m), 32'd0);

        // ---------------- period saturation with PERIOD_W=4 ----------------
        sig_o = 1'b1;
        repeat (3) step();
        check("ovf_first_pe", 32'(pe_o), 32'd1);
        check("ovf_first_valid", 32'(pv_o), 32'd0);
        repeat (2) step();
        sig_o = 1'b0;
        repeat (15) step();
        sig_o = 1'b1;
        repeat (3) step();
        check("ovf_period_sat", 32'(period_o), 32'd15);
        check("ovf_flag_set", 32'(ovf_o), 32'd1);
        check("ovf_valid", 32'(pv_o), 32'd1);
        repeat (2) step();
        sig_o = 1'b0;
        repeat (5) step();
        sig_o = 1'b1;
        repeat (3) step();
        check("ovf_period_10", 32'(period_o), 32'd10);
        check("ovf_flag_clr", 32'(ovf_o), 32'd0);

        // ---------------- edge_count wrap with CNT_W=2 ----------------
        for (int i = 1; i <= 5; i++) begin
            sig_w = 1'b1;
            repeat (3) step();
            check("wrap_edge_count", 32'(ec_w), 32'(i % 4));
            step();
            sig_w = 1'b0;
            repeat (4) step();
        end
        check("wrap_after5", 32'(ec_w), 32'd1);

        // ---------------- reset with sig high ----------------
        sig_w = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("rst2_edge_count", 32'(ec_w), 32'd0);
        check("rst2_pe", 32'(pe_w), 32'd0);
        check("rst2_period", period_w, 32'd0);
        check("rst2_period_valid", 32'(pv_w), 32'd0);
        pe_snap = pe_cnt_w;
        rst = 1'b0;
        repeat (10) step();
        check("rst2_single_pe", 32'(pe_cnt_w - pe_snap), 32'd1);
        check("rst2_edge_count_after", 32'(ec_w), 32'd1);
        check("rst2_period_valid_after", 32'(pv_w), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
